toast_dmem_mmio: RTL and testbench



---
 rtl/toast_dmem_mmio.sv | 200 ++++++++++++++++++++
 tb/tb_toast_dmem_mmio.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/toast_dmem_mmio.sv
// toast_dmem_mmio -- data-side memory subsystem behind the core's MEM stage.
//
// Terminates the core's DMEM port with a byte-writable word RAM at region 0
// (0x0xxx_xxxx) and a four-register MMIO page at 0x8000_0000:
//   +0x0 TXDATA   (W: push byte into console TX FIFO, R: 0)
//   +0x4 STATUS   (R: bit0 full, bit1 empty, bit2 overflow, [15:8] count)
//   +0x8 CYCLE_LO (R: counter[31:0], latches counter[63:32] into a shadow)
//   +0xC CYCLE_HI (R: shadow)
// Every other address is unmapped: it reads 0, drops writes and sets bus_err_o.
// Read data is returned one cycle after the address is presented.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   DMEM_addr_i            byte address from the core
//   DMEM_wr_byte_en_i      per-lane write enable (0000 = read/idle)
//   DMEM_wr_data_i         write data, lane i = bits [8i+7:8i]
//   DMEM_rst_i             core request to clear the returned read data
//   DMEM_rd_data_o         read data for the address of the previous cycle
//   tx_valid_o/tx_data_o   TX FIFO head (first-word fall-through)
//   tx_ready_i             consumer accepts the head byte
//   bus_err_o              sticky unmapped-access flag
module toast_dmem_mmio #(
  parameter int unsigned RAM_DEPTH  = 4096,
  parameter int unsigned FIFO_DEPTH = 16,
  // Cycle counter value loaded at reset; 0 in normal use.
  parameter logic [63:0] CYCLE_INIT = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] DMEM_addr_i,
  input  logic [3:0]  DMEM_wr_byte_en_i,
  input  logic [31:0] DMEM_wr_data_i,
  input  logic        DMEM_rst_i,
  output logic [31:0] DMEM_rd_data_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        bus_err_o
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_CYCLE_LO = 2'd2;
  localparam logic [1:0] REG_CYCLE_HI = 2'd3;

  // ---------------- address decode ----------------
  logic          sel_ram;
  logic          sel_mmio;
  logic          sel_unmapped;
  logic [1:0]    mmio_reg;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_lsbs;

  assign sel_ram          = (DMEM_addr_i[31:28] == 4'h0);
  assign sel_mmio         = (DMEM_addr_i[31:4] == 28'h800_0000);
  assign sel_unmapped     = !sel_ram && !sel_mmio;
  assign mmio_reg         = DMEM_addr_i[3:2];
  assign ram_idx          = DMEM_addr_i[AW+1:2];
  assign unused_addr_lsbs = ^DMEM_addr_i[1:0];

  // ---------------- RAM: one byte-wide array per lane ----------------
  // Splitting by lane keeps each array a plain single-port RAM with a
  // registered read; the non-blocking write gives read-before-write.
  logic [31:0] ram_rd_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk_i) begin
        if (sel_ram && DMEM_wr_byte_en_i[gi]) begin
          mem[ram_idx] <= DMEM_wr_data_i[8*gi +: 8];
        end
        rd_q <= mem[ram_idx];
      end

      assign ram_rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [PW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        push;
  logic        pop;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push_req   = sel_mmio && (mmio_reg == REG_TXDATA) && DMEM_wr_byte_en_i[0];
  assign pop        = !fifo_empty && tx_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the consumer takes the head.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= DMEM_wr_data_i[7:0];
  end

  // Head is read combinationally so the byte is visible with tx_valid_o.
  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_mem[rd_ptr_q[PW-1:0]];

  // ---------------- cycle counter and HI shadow ----------------
  logic [63:0] cycle_q;
  logic [31:0] shadow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q  <= CYCLE_INIT;
      shadow_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      // Latching HI together with the LO read makes a LO-then-HI pair
      // coherent even across a carry.
      if (sel_mmio && (mmio_reg == REG_CYCLE_LO)) shadow_q <= cycle_q[63:32];
    end
  end

  // ---------------- bus error ----------------
  logic bus_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)             bus_err_q <= 1'b0;
    else if (sel_unmapped) bus_err_q <= 1'b1;
  end

  assign bus_err_o = bus_err_q;

  // ---------------- read-data path ----------------
  logic [31:0] status_word;
  logic [31:0] mmio_rd_d, mmio_rd_q;
  logic        rd_from_ram_q;
  logic        rd_clear_q;

  assign status_word = {16'h0, 8'(fifo_count), 5'h0, overflow_q, fifo_empty, fifo_full};

  // Unmapped addresses fall through to 0 here.
  always_comb begin
    mmio_rd_d = '0;
    if (sel_mmio) begin
      case (mmio_reg)
        REG_STATUS:   mmio_rd_d = status_word;
        REG_CYCLE_LO: mmio_rd_d = cycle_q[31:0];
        REG_CYCLE_HI: mmio_rd_d = shadow_q;
        default:      mmio_rd_d = '0;
      endcase
    end
  end

  // The RAM word is captured in its own register; the final select uses
  // only registered state, so the output stays one cycle behind the address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_clear_q    <= 1'b1;
      rd_from_ram_q <= 1'b0;
      mmio_rd_q     <= '0;
    end else begin
      rd_clear_q    <= DMEM_rst_i;
      rd_from_ram_q <= sel_ram;
      mmio_rd_q     <= mmio_rd_d;
    end
  end

  assign DMEM_rd_data_o = rd_clear_q    ? 32'h0 :
                          rd_from_ram_q ? ram_rd_word : mmio_rd_q;

endmodule

// File: tb/tb_toast_dmem_mmio.sv
module tb_toast_dmem_mmio;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] DMEM_addr_i = '0;
  logic [3:0]  DMEM_wr_byte_en_i = '0;
  logic [31:0] DMEM_wr_data_i = '0;
  logic        DMEM_rst_i = 1'b0;
  logic [31:0] DMEM_rd_data_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        bus_err_o;

  always #5 clk_i = ~clk_i;

  toast_dmem_mmio #(
    .RAM_DEPTH (4096),
    .FIFO_DEPTH(16),
    .CYCLE_INIT(64'h0000_0000_FFFF_FFFE)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .DMEM_addr_i      (DMEM_addr_i),
    .DMEM_wr_byte_en_i(DMEM_wr_byte_en_i),
    .DMEM_wr_data_i   (DMEM_wr_data_i),
    .DMEM_rst_i       (DMEM_rst_i),
    .DMEM_rd_data_o   (DMEM_rd_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_data_o        (tx_data_o),
    .tx_ready_i       (tx_ready_i),
    .bus_err_o        (bus_err_o)
  );

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_LO  = 32'h8000_0008;
  localparam logic [31:0] A_HI  = 32'h8000_000C;

  typedef struct {
    int          due;
    logic [31:0] data;
    string       name;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[%0t] FAIL %s: got %08h, expected %08h", $time, name, act, exp);
    end else begin
      $display("[%0t] ok   %s: got %08h", $time, name, act);
    end
  endtask

  // Monitor: read responses are due one cycle after issue; TX bytes are
  // compared whenever a handshake is about to happen at the next edge.
  always @(negedge clk_i) begin
    rd_exp_t e;
    logic [7:0] b;
    while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      chk(e.name, DMEM_rd_data_o, e.data);
    end
    if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
      if (tx_q.size() == 0) begin
        chk("tx unexpected byte", {24'h0, tx_data_o}, 32'hFFFF_FFFF);
      end else begin
        b = tx_q.pop_front();
        chk("tx byte", {24'h0, tx_data_o}, {24'h0, b});
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input bit drst, input bit chk_en, input logic [31:0] exp,
                     input string nm);
    rd_exp_t e;
    DMEM_addr_i       = a;
    DMEM_wr_byte_en_i = be;
    DMEM_wr_data_i    = wd;
    DMEM_rst_i        = drst;
    if (chk_en) begin
      e.due  = cyc + 1;
      e.data = exp;
      e.name = nm;
      rd_q.push_back(e);
    end
    @(posedge clk_i); #1;
    DMEM_addr_i       = '0;
    DMEM_wr_byte_en_i = '0;
    DMEM_wr_data_i    = '0;
    DMEM_rst_i        = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus(a, be, wd, 1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus(a, 4'b0000, 32'h0, 1'b0, 1'b1, exp, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    repeat (n) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 40 && tx_valid_o; i++) idle(1);
    tx_ready_i = 1'b0;
    chk({nm, " drained tx_valid"}, {31'h0, tx_valid_o}, 32'h0);
    chk({nm, " expected bytes left"}, tx_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk_i); #1;
    do_reset(2);
    chk("reset rd_data", DMEM_rd_data_o, 32'h0);
    chk("reset tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("reset bus_err", {31'h0, bus_err_o}, 32'h0);

    // RAM byte lanes
    wr(32'h100, 4'b1111, 32'hDEAD_BEEF);
    wr(32'h100, 4'b0010, 32'h0000_5500);
    rd(32'h100, 32'hDEAD_55EF, "ram lane1 merge");

    // Read-before-write, DMEM_rst_i, aliasing
    wr(32'h40, 4'b1111, 32'h0);
    bus(32'h40, 4'b1111, 32'h1111_1111, 1'b0, 1'b1, 32'h0, "ram read-before-write");
    rd(32'h40, 32'h1111_1111, "ram reread");
    bus(32'h40, 4'b0000, 32'h0, 1'b1, 1'b1, 32'h0, "DMEM_rst clears rd_data");
    rd(32'h40, 32'h1111_1111, "ram after DMEM_rst");
    wr(32'h40, 4'b1000, 32'hAB00_0000);
    rd(32'h43, 32'hAB11_1111, "ram lane3 + addr lsbs ignored");
    rd(32'h0000_4040, 32'hAB11_1111, "ram alias wrap");

    // FIFO fill, overflow, drain
    rd(A_ST, 32'h0000_0002, "status empty");
    rd(A_TX, 32'h0, "txdata reads 0");
    for (int i = 0; i < 16; i++) begin
      wr(A_TX, 4'b0001, i);
      tx_q.push_back(8'(i));
    end
    rd(A_ST, 32'h0000_1001, "status full");
    wr(A_TX, 4'b0001, 32'h0000_00AA);
    rd(A_ST, 32'h0000_1005, "status full+overflow");
    chk("fifo head", {24'h0, tx_data_o}, 32'h0);
    drain("fill16");
    rd(A_ST, 32'h0000_0006, "status empty+overflow");

    // Push with pop on a full FIFO
    do_reset(1);
    chk("post-reset tx_valid", {31'h0, tx_valid_o}, 32'h0);
    wr(A_TX, 4'b0001, 32'h10);
    tx_q.push_back(8'h10);
    chk("tx_valid after push", {31'h0, tx_valid_o}, 32'h1);
    for (int i = 1; i < 16; i++) begin
      wr(A_TX, 4'b0001, 32'h10 + i);
      tx_q.push_back(8'(8'h10 + i));
    end
    tx_ready_i = 1'b1;
    wr(A_TX, 4'b0001, 32'h77);
    tx_q.push_back(8'h77);
    tx_ready_i = 1'b0;
    rd(A_ST, 32'h0000_1001, "status push+pop full");
    drain("push+pop");

    // Status write ignored; counter with carry through the shadow
    wr(A_ST, 4'b1111, 32'hFFFF_FFFF);
    rd(A_ST, 32'h0000_0002, "status write ignored");
    do_reset(2);
    rd(A_HI, 32'h0, "cycle hi after reset");
    rd(A_LO, 32'hFFFF_FFFF, "cycle lo pre-carry");
    rd(A_HI, 32'h0, "cycle hi pre-carry");
    rd(A_LO, 32'h0000_0001, "cycle lo post-carry");
    rd(A_HI, 32'h0000_0001, "cycle hi post-carry");

    // Unmapped accesses
    wr(32'h200, 4'b1111, 32'h1234_5678);
    wr(A_TX, 4'b0001, 32'h5A);
    chk("bus_err before", {31'h0, bus_err_o}, 32'h0);
    rd(32'h4000_0000, 32'h0, "unmapped read");
    chk("bus_err set", {31'h0, bus_err_o}, 32'h1);
    wr(32'h4000_0200, 4'b1111, 32'hFFFF_FFFF);
    wr(32'h8000_0010, 4'b0001, 32'h99);
    idle(3);
    chk("bus_err sticky", {31'h0, bus_err_o}, 32'h1);
    rd(32'h200, 32'h1234_5678, "ram untouched by unmapped");
    rd(A_ST, 32'h0000_0100, "fifo untouched by unmapped");
    chk("tx_valid before reset", {31'h0, tx_valid_o}, 32'h1);
    chk("tx head before reset", {24'h0, tx_data_o}, 32'h5A);
    do_reset(1);
    chk("mid-op reset tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("mid-op reset bus_err", {31'h0, bus_err_o}, 32'h0);
    chk("mid-op reset rd_data", DMEM_rd_data_o, 32'h0);

    idle(2);
    chk("scoreboard empty", rd_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
